// File: rtl/ps_pkg.sv
// Shared definitions for the program sequencer: reset address, next-address select codes
// and the jump-target helper.
package ps_pkg;

  localparam int unsigned PS_RESET_ADDR = 0;

  typedef enum logic [2:0] {
    SEL_RST,
    SEL_JMP,
    SEL_CALL,
    SEL_RET,
    SEL_INC
  } ps_sel_e;

  // Jump/call target: nibble in the top four bits of a width-bit address, zeros below.
  function automatic logic [31:0] tgt(input logic [3:0] nibble, input int unsigned width);
    return 32'(nibble) << (width - 4);
  endfunction

endpackage

// File: rtl/ps_ret_stack.sv
// Hardware return-address stack for call/ret; sp counts 0..DEPTH, contents are not reset.
module ps_ret_stack
  import ps_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SPW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty,
  output logic [SPW-1:0]   sp
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d;
  logic [SPW-2:0]   wr_idx, rd_idx;

  assign wr_idx = sp_q[SPW-2:0];
  assign rd_idx = wr_idx - (SPW-1)'(1);
  assign full   = (sp_q == SPW'(DEPTH));
  assign empty  = (sp_q == '0);
  assign top    = mem_q[rd_idx];
  assign sp     = sp_q;

  always_comb begin
    sp_d = sp_q;
    if (push && !full)
      sp_d = sp_q + SPW'(1);
    else if (pop && !empty)
      sp_d = sp_q - SPW'(1);
  end

  always_ff @(posedge clk) begin
    if (sync_reset)
      sp_q <= '0;
    else
      sp_q <= sp_d;
  end

  always_ff @(posedge clk) begin
    if (push && !full && !sync_reset)
      mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/program_sequencer_stack.sv
// Program sequencer with jump resolution and a return-address stack for call/ret.
// Optional PS_STALL_EN adds a stall input that freezes pc, sp and the stack.
module program_sequencer_stack
  import ps_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                sync_reset,
  input  logic                jmp,
  input  logic                jmp_nz,
  input  logic                dont_jmp,
  input  logic [3:0]          ir_nibble,
  input  logic                call,
  input  logic                ret,
`ifdef PS_STALL_EN
  input  logic                stall,
`endif
  output logic [PC_WIDTH-1:0] pm_addr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] from_PS,
  output logic                stack_ovf,
  output logic                stack_unf
);

  localparam int unsigned SPW = $clog2(STACK_DEPTH) + 1;

  logic [PC_WIDTH-1:0] pc_q, pc_inc, target, stk_top;
  logic                ovf_q, unf_q, ovf_set, unf_set;
  logic                push, pop, stk_full, stk_empty, stall_act, jump_taken;
  logic [SPW-1:0]      stk_sp;
  ps_sel_e             sel;

`ifdef PS_STALL_EN
  assign stall_act = stall;
`else
  assign stall_act = 1'b0;
`endif

  assign pc_inc     = pc_q + PC_WIDTH'(1);
  assign target     = PC_WIDTH'(tgt(ir_nibble, PC_WIDTH));
  assign jump_taken = jmp | (jmp_nz & ~dont_jmp);

  // Priority: reset, stall, jump, call, ret; a ret on an empty stack falls through to pc+1.
  always_comb begin
    sel     = SEL_INC;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (sync_reset) begin
      sel = SEL_RST;
    end else if (!stall_act) begin
      if (jump_taken) begin
        sel = SEL_JMP;
      end else if (call) begin
        sel     = SEL_CALL;
        push    = 1'b1;
        ovf_set = stk_full;
      end else if (ret) begin
        if (stk_empty) begin
          unf_set = 1'b1;
        end else begin
          sel = SEL_RET;
          pop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pm_addr = pc_inc;
    case (sel)
      SEL_RST:           pm_addr = PC_WIDTH'(PS_RESET_ADDR);
      SEL_JMP, SEL_CALL: pm_addr = target;
      SEL_RET:           pm_addr = stk_top;
      default:           pm_addr = stall_act ? pc_q : pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pc_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pm_addr;
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
    end
  end

  ps_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_WIDTH),
    .SPW   (SPW)
  ) u_stack (
    .clk        (clk),
    .sync_reset (sync_reset),
    .push       (push),
    .pop        (pop),
    .push_data  (pc_inc),
    .top        (stk_top),
    .full       (stk_full),
    .empty      (stk_empty),
    .sp         (stk_sp)
  );

  always_comb assert (stk_sp <= SPW'(STACK_DEPTH));

  assign pc        = pc_q;
  assign from_PS   = pc_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: tb/tb_program_sequencer_stack.sv
// Directed self-checking bench for program_sequencer_stack (stall scenario under PS_STALL_EN).
module tb_program_sequencer_stack;

  logic       clk = 1'b0;
  logic       sync_reset, jmp, jmp_nz, dont_jmp, call, ret;
  logic [3:0] ir_nibble;
  logic [7:0] pm_addr, pc, from_PS;
  logic       stack_ovf, stack_unf;
`ifdef PS_STALL_EN
  logic       stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  program_sequencer_stack #(
    .PC_WIDTH    (8),
    .STACK_DEPTH (4)
  ) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .jmp        (jmp),
    .jmp_nz     (jmp_nz),
    .dont_jmp   (dont_jmp),
    .ir_nibble  (ir_nibble),
    .call       (call),
    .ret        (ret),
`ifdef PS_STALL_EN
    .stall      (stall),
`endif
    .pm_addr    (pm_addr),
    .pc         (pc),
    .from_PS    (from_PS),
    .stack_ovf  (stack_ovf),
    .stack_unf  (stack_unf)
  );

  task automatic idle_inputs();
    sync_reset = 1'b0; jmp = 1'b0; jmp_nz = 1'b0; dont_jmp = 1'b0;
    call = 1'b0; ret = 1'b0; ir_nibble = 4'h0;
`ifdef PS_STALL_EN
    stall = 1'b0;
`endif
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
  endtask

  task automatic go_to(input logic [3:0] nib, input int unsigned extra);
    idle_inputs();
    jmp = 1'b1; ir_nibble = nib;
    step();
    idle_inputs();
    for (int unsigned i = 0; i < extra; i++) step();
  endtask

  task automatic test_reset();
    idle_inputs();
    sync_reset = 1'b1;
    #1;
    total++; if (pm_addr !== 8'h00) begin bad++; $display("FAIL rst_pm_addr got=%h exp=00", pm_addr); end
    step();
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL rst_pc got=%h exp=00", pc); end
    total++; if (from_PS !== 8'h00) begin bad++; $display("FAIL rst_from_PS got=%h exp=00", from_PS); end
    total++; if ({stack_ovf, stack_unf} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {stack_ovf, stack_unf}); end
    sync_reset = 1'b0;
    #1;
    for (int unsigned i = 1; i <= 5; i++) begin
      total++; if (pm_addr !== 8'(i)) begin bad++; $display("FAIL seq_pm_addr[%0d] got=%h exp=%h", i, pm_addr, 8'(i)); end
      total++; if (from_PS !== 8'(i - 1)) begin bad++; $display("FAIL seq_from_PS[%0d] got=%h exp=%h", i, from_PS, 8'(i - 1)); end
      step();
    end
  endtask

  task automatic test_jump();
    go_to(4'h3, 10);
    total++; if (pc !== 8'h3A) begin bad++; $display("FAIL jmp_setup_pc got=%h exp=3a", pc); end
    jmp = 1'b1; ir_nibble = 4'h7;
    #1;
    total++; if (pm_addr !== 8'h70) begin bad++; $display("FAIL jmp_pm_addr got=%h exp=70", pm_addr); end
    step();
    total++; if (pc !== 8'h70) begin bad++; $display("FAIL jmp_pc got=%h exp=70", pc); end
    idle_inputs();
    jmp_nz = 1'b1; dont_jmp = 1'b1; ir_nibble = 4'h9;
    #1;
    total++; if (pm_addr !== 8'h71) begin bad++; $display("FAIL jnz_suppressed got=%h exp=71", pm_addr); end
    step();
    dont_jmp = 1'b0;
    #1;
    total++; if (pm_addr !== 8'h90) begin bad++; $display("FAIL jnz_taken got=%h exp=90", pm_addr); end
    step();
    idle_inputs();
  endtask

  task automatic test_call_ret();
    go_to(4'h1, 2);
    call = 1'b1; ir_nibble = 4'h4;
    #1;
    total++; if (pm_addr !== 8'h40) begin bad++; $display("FAIL call_pm_addr got=%h exp=40", pm_addr); end
    step();
    idle_inputs();
    step(); step();
    ret = 1'b1;
    #1;
    total++; if (pm_addr !== 8'h13) begin bad++; $display("FAIL ret_pm_addr got=%h exp=13", pm_addr); end
    step();
    total++; if ({stack_ovf, stack_unf} !== 2'b00) begin bad++; $display("FAIL call_ret_flags got=%b exp=00", {stack_ovf, stack_unf}); end
    // Stack must be empty again: another ret falls through to pc+1.
    #1;
    total++; if (pm_addr !== 8'h14) begin bad++; $display("FAIL ret_empty_pm_addr got=%h exp=14", pm_addr); end
    idle_inputs();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_ret [4] = '{8'h31, 8'h21, 8'h11, 8'h01};
    do_reset();
    for (int unsigned i = 1; i <= 5; i++) begin
      call = 1'b1; ir_nibble = 4'(i);
      #1;
      total++; if (pm_addr !== {4'(i), 4'h0}) begin bad++; $display("FAIL nest_call[%0d] got=%h exp=%h", i, pm_addr, {4'(i), 4'h0}); end
      step();
    end
    call = 1'b0;
    total++; if (stack_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", stack_ovf); end
    total++; if (pc !== 8'h50) begin bad++; $display("FAIL ovf_pc got=%h exp=50", pc); end
    ret = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      total++; if (pm_addr !== exp_ret[i]) begin bad++; $display("FAIL lifo_ret[%0d] got=%h exp=%h", i, pm_addr, exp_ret[i]); end
      step();
    end
    #1;
    total++; if (pm_addr !== 8'h02) begin bad++; $display("FAIL unf_pm_addr got=%h exp=02", pm_addr); end
    step();
    total++; if ({stack_ovf, stack_unf} !== 2'b11) begin bad++; $display("FAIL unf_flags got=%b exp=11", {stack_ovf, stack_unf}); end
    idle_inputs();
  endtask

  task automatic test_wrap_combo();
    do_reset();
    go_to(4'hF, 15);
    #1;
    total++; if (pm_addr !== 8'h00) begin bad++; $display("FAIL wrap_pm_addr got=%h exp=00", pm_addr); end
    step();
    call = 1'b1; ret = 1'b1; ir_nibble = 4'h6;
    #1;
    total++; if (pm_addr !== 8'h60) begin bad++; $display("FAIL call_ret_pm_addr got=%h exp=60", pm_addr); end
    step();
    idle_inputs();
    ret = 1'b1;
    #1;
    total++; if (pm_addr !== 8'h01) begin bad++; $display("FAIL call_ret_push got=%h exp=01", pm_addr); end
    step();
    total++; if (stack_unf !== 1'b0) begin bad++; $display("FAIL call_ret_unf got=%b exp=0", stack_unf); end
    idle_inputs();
    jmp = 1'b1; call = 1'b1; ir_nibble = 4'h8;
    #1;
    total++; if (pm_addr !== 8'h80) begin bad++; $display("FAIL jmp_call_pm_addr got=%h exp=80", pm_addr); end
    step();
    idle_inputs();
    ret = 1'b1;
    #1;
    total++; if (pm_addr !== 8'h81) begin bad++; $display("FAIL jmp_call_nopush got=%h exp=81", pm_addr); end
    step();
    total++; if (stack_unf !== 1'b1) begin bad++; $display("FAIL jmp_call_unf got=%b exp=1", stack_unf); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_call();
    go_to(4'h2, 0);
    call = 1'b1; ir_nibble = 4'h5;
    step();
    call = 1'b1; ir_nibble = 4'hA; sync_reset = 1'b1;
    #1;
    total++; if (pm_addr !== 8'h00) begin bad++; $display("FAIL rst_call_pm_addr got=%h exp=00", pm_addr); end
    step();
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL rst_call_pc got=%h exp=00", pc); end
    total++; if ({stack_ovf, stack_unf} !== 2'b00) begin bad++; $display("FAIL rst_call_flags got=%b exp=00", {stack_ovf, stack_unf}); end
    idle_inputs();
    ret = 1'b1;
    #1;
    total++; if (pm_addr !== 8'h01) begin bad++; $display("FAIL rst_call_sp got=%h exp=01", pm_addr); end
    step();
    idle_inputs();
  endtask

`ifdef PS_STALL_EN
  task automatic test_stall();
    do_reset();
    go_to(4'h2, 0);
    stall = 1'b1; jmp = 1'b1; call = 1'b1; ir_nibble = 4'h9;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      total++; if (pm_addr !== 8'h20) begin bad++; $display("FAIL stall_pm_addr[%0d] got=%h exp=20", i, pm_addr); end
      step();
      total++; if (pc !== 8'h20) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=20", i, pc); end
    end
    idle_inputs();
    #1;
    total++; if (pm_addr !== 8'h21) begin bad++; $display("FAIL unstall_pm_addr got=%h exp=21", pm_addr); end
    step();
    total++; if (pc !== 8'h21) begin bad++; $display("FAIL unstall_pc got=%h exp=21", pc); end
    ret = 1'b1;
    #1;
    total++; if (pm_addr !== 8'h22) begin bad++; $display("FAIL stall_nopush got=%h exp=22", pm_addr); end
    step();
    idle_inputs();
  endtask
`endif

  initial begin
    idle_inputs();
    step();
    test_reset();
    test_jump();
    test_call_ret();
    test_overflow();
    test_wrap_combo();
    test_reset_mid_call();
`ifdef PS_STALL_EN
    test_stall();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
